// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
// Module      : int_controller
// Description : Four-source, rising-edge interrupt controller. It keeps a
//               pending/mask register bank, dispatches the lowest-numbered
//               ready source with a vector of VBASE + 4*src, and holds it in
//               service until the CPU signals ret. There is no preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module int_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] irq_src,
    input  logic       cpu_ret,
    input  logic       bus_w_en,
    input  logic [1:0] bus_addr,
    input  logic [7:0] bus_w_data,
    output logic [7:0] bus_r_data,
    output logic       int_req,
    output logic [7:0] int_en,
    output logic [7:0] int_vec
);

    localparam logic [1:0] c_addr_ctrl  = 2'd0;
    localparam logic [1:0] c_addr_vbase = 2'd1;
    localparam logic [1:0] c_addr_pend  = 2'd2;
    localparam logic [1:0] c_addr_stat  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DISPATCH   = 2'd1,
        ST_IN_SERVICE = 2'd2,
        ST_ILLEGAL    = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       r_gie;
    logic [3:0] r_mask;
    logic [7:0] r_vbase;
    logic [3:0] r_pending;
    logic [3:0] r_prev;
    logic [1:0] r_cur_src;
    logic       r_in_svc;
    logic       r_int_req;
    logic [7:0] r_int_vec;

    logic [3:0] w_edge;
    logic [3:0] w_ready;
    logic       w_dispatch;
    logic [1:0] w_sel;
    logic [3:0] w_bus_clr;
    logic [3:0] w_disp_clr;

    assign w_edge     = irq_src & ~r_prev;
    assign w_ready    = r_pending & r_mask;
    // Decision is taken from registered CTRL/PEND, so a bus write on the same
    // edge cannot influence it.
    assign w_dispatch = (r_state == ST_IDLE) && r_gie && (w_ready != 4'b0000);
    assign w_bus_clr  = (bus_w_en && (bus_addr == c_addr_pend)) ? bus_w_data[3:0] : 4'b0000;
    assign w_disp_clr = w_dispatch ? (4'b0001 << w_sel) : 4'b0000;

    // Lowest-index ready source has priority.
    always_comb begin
        w_sel = 2'd0;
        if (w_ready[0])      w_sel = 2'd0;
        else if (w_ready[1]) w_sel = 2'd1;
        else if (w_ready[2]) w_sel = 2'd2;
        else if (w_ready[3]) w_sel = 2'd3;
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_dispatch) w_state_next = ST_DISPATCH;
            ST_DISPATCH:   w_state_next = ST_IN_SERVICE;
            ST_IN_SERVICE: if (cpu_ret) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Edge capture and pending bits; a new edge wins over any clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev    <= 4'b0000;
            r_pending <= 4'b0000;
        end else begin
            r_prev    <= irq_src;
            r_pending <= (r_pending & ~(w_bus_clr | w_disp_clr)) | w_edge;
        end
    end

    // Dispatch bookkeeping: selected source, vector, request and service flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur_src <= 2'd0;
            r_int_vec <= 8'h00;
            r_int_req <= 1'b0;
            r_in_svc  <= 1'b0;
        end else begin
            if (w_dispatch) begin
                r_cur_src <= w_sel;
                r_int_vec <= r_vbase + {4'b0000, w_sel, 2'b00};
            end
            r_int_req <= (w_state_next == ST_DISPATCH);
            r_in_svc  <= (w_state_next == ST_IN_SERVICE);
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gie   <= 1'b0;
            r_mask  <= 4'b0000;
            r_vbase <= 8'h00;
        end else if (bus_w_en) begin
            if (bus_addr == c_addr_ctrl) begin
                r_gie  <= bus_w_data[7];
                r_mask <= bus_w_data[3:0];
            end
            if (bus_addr == c_addr_vbase) begin
                r_vbase <= bus_w_data;
            end
        end
    end

    // Combinational register read-back.
    always_comb begin
        bus_r_data = 8'h00;
        case (bus_addr)
            c_addr_ctrl:  bus_r_data = {r_gie, 3'b000, r_mask};
            c_addr_vbase: bus_r_data = r_vbase;
            c_addr_pend:  bus_r_data = {4'b0000, r_pending};
            c_addr_stat:  bus_r_data = {r_state, 2'b00, r_in_svc, r_cur_src, r_int_req};
            default:      bus_r_data = 8'h00;
        endcase
    end

    assign int_req = r_int_req;
    assign int_en  = {7'b0000000, r_gie};
    assign int_vec = r_int_vec;

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_controller
// Description : Self-checking bench for int_controller. Directed scenarios
//               followed by random traffic, compared every cycle against a
//               behavioural model of the controller's register/dispatch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_controller;

    logic       clock;
    logic       reset;
    logic [3:0] irq_src;
    logic       cpu_ret;
    logic       bus_w_en;
    logic [1:0] bus_addr;
    logic [7:0] bus_w_data;
    logic [7:0] bus_r_data;
    logic       int_req;
    logic [7:0] int_en;
    logic [7:0] int_vec;

    int total = 0;
    int bad   = 0;

    int_controller dut (
        .clock      (clock),
        .reset      (reset),
        .irq_src    (irq_src),
        .cpu_ret    (cpu_ret),
        .bus_w_en   (bus_w_en),
        .bus_addr   (bus_addr),
        .bus_w_data (bus_w_data),
        .bus_r_data (bus_r_data),
        .int_req    (int_req),
        .int_en     (int_en),
        .int_vec    (int_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state (phase: 0 idle, 1 dispatching, 2 in service).
    bit       m_valid = 0;
    int       m_phase;
    bit       m_gie;
    bit [3:0] m_mask;
    bit [7:0] m_vbase;
    bit [3:0] m_pend;
    bit [3:0] m_prev;
    int       m_src;
    bit       m_svc;
    bit       m_req;
    bit [7:0] m_vec;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [7:0] model_read(input bit [1:0] a);
        bit [1:0] st;
        bit [1:0] src;
        st  = m_phase[1:0];
        src = m_src[1:0];
        case (a)
            2'd0:    return {m_gie, 3'b000, m_mask};
            2'd1:    return m_vbase;
            2'd2:    return {4'b0000, m_pend};
            default: return {st, 2'b00, m_svc, src, m_req};
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_step(input bit [3:0] irq, input bit ret, input bit we,
                              input bit [1:0] a, input bit [7:0] wd, input bit rs);
        int       next_phase;
        bit [3:0] ready;
        bit [3:0] clr;
        if (rs) begin
            m_phase = 0; m_gie = 0; m_mask = 0; m_vbase = 0; m_pend = 0;
            m_prev = 0; m_src = 0; m_svc = 0; m_req = 0; m_vec = 0;
            m_valid = 1;
            return;
        end
        next_phase = m_phase;
        clr = 4'b0000;
        ready = m_pend & m_mask;
        if (m_phase == 0) begin
            if (m_gie && ready != 0) begin
                for (int i = 3; i >= 0; i--) if (ready[i]) m_src = i;
                m_vec = 8'((int'(m_vbase) + 4 * m_src) % 256);
                clr[m_src] = 1'b1;
                next_phase = 1;
            end
        end else if (m_phase == 1) begin
            next_phase = 2;
        end else if (ret) begin
            next_phase = 0;
        end
        if (we && a == 2'd2) clr = clr | wd[3:0];
        m_pend = (m_pend & ~clr) | (irq & ~m_prev);
        if (we && a == 2'd0) begin m_gie = wd[7]; m_mask = wd[3:0]; end
        if (we && a == 2'd1) m_vbase = wd;
        m_prev  = irq;
        m_phase = next_phase;
        m_svc   = (next_phase == 2);
        m_req   = (next_phase == 1);
    endtask

    // One clock: drive at negedge, compare against the model, then step it.
    task automatic cyc(input logic [3:0] irq, input logic ret, input logic we,
                       input logic [1:0] a, input logic [7:0] wd, input logic rs);
        @(negedge clock);
        irq_src = irq; cpu_ret = ret; bus_w_en = we;
        bus_addr = a; bus_w_data = wd; reset = rs;
        #1;
        if (m_valid) begin
            check("int_req", {7'b0, int_req}, {7'b0, m_req});
            check("int_en", int_en, {7'b0, m_gie});
            check("int_vec", int_vec, m_vec);
            check($sformatf("rd%0d", a), bus_r_data, model_read(a));
        end
        @(posedge clock);
        #1;
        model_step(irq, ret, we, a, wd, rs);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0, 1'b0, a, 8'h00, 1'b0);
    endtask

    logic [3:0] irq_drv;
    logic [1:0] ra;
    logic [7:0] rd;
    logic       rw;

    initial begin
        irq_src = 0; cpu_ret = 0; bus_w_en = 0; bus_addr = 0; bus_w_data = 0; reset = 1;

        // Basic dispatch of source 0 and return.
        cyc(4'b0000, 0, 0, 2'd3, 8'h00, 1);
        check("rst_vec", int_vec, 8'h00);
        check("rst_stat", bus_r_data, 8'h00);
        cyc(4'b0000, 0, 1, 2'd0, 8'h81, 0);
        cyc(4'b0000, 0, 1, 2'd1, 8'h40, 0);
        cyc(4'b0001, 0, 0, 2'd3, 8'h00, 0);
        cyc(4'b0000, 0, 0, 2'd3, 8'h00, 0);
        check("r21_req", {7'b0, int_req}, 8'h01);
        check("r21_vec", int_vec, 8'h40);
        idle(1, 2'd3);
        check("r21_req_off", {7'b0, int_req}, 8'h00);
        check("r21_stat", bus_r_data, 8'h88);
        cyc(4'b0000, 1, 0, 2'd3, 8'h00, 0);
        check("r21_idle", bus_r_data, 8'h00);

        // Simultaneous sources: priority then second dispatch after ret.
        cyc(4'b0000, 0, 0, 2'd0, 8'h00, 1);
        cyc(4'b0000, 0, 1, 2'd0, 8'h8F, 0);
        cyc(4'b0000, 0, 1, 2'd1, 8'h20, 0);
        cyc(4'b1010, 0, 0, 2'd2, 8'h00, 0);
        cyc(4'b0000, 0, 0, 2'd2, 8'h00, 0);
        check("r22_vec1", int_vec, 8'h24);
        idle(2, 2'd2);
        cyc(4'b0000, 1, 0, 2'd2, 8'h00, 0);
        cyc(4'b0000, 0, 0, 2'd2, 8'h00, 0);
        check("r22_vec2", int_vec, 8'h2C);
        idle(2, 2'd3);
        cyc(4'b0000, 1, 0, 2'd3, 8'h00, 0);

        // Masked by gie: pending only, then enable dispatches.
        cyc(4'b0000, 0, 0, 2'd0, 8'h00, 1);
        cyc(4'b0000, 0, 1, 2'd0, 8'h0F, 0);
        cyc(4'b0100, 0, 0, 2'd2, 8'h00, 0);
        idle(3, 2'd2);
        check("r23_pend", bus_r_data, 8'h04);
        check("r23_noreq", {7'b0, int_req}, 8'h00);
        cyc(4'b0000, 0, 1, 2'd0, 8'h8F, 0);
        cyc(4'b0000, 0, 0, 2'd2, 8'h00, 0);
        check("r23_vec", int_vec, 8'h08);
        check("r23_pend0", bus_r_data, 8'h00);
        idle(2, 2'd2);
        cyc(4'b0000, 1, 0, 2'd2, 8'h00, 0);

        // Vector wrap.
        cyc(4'b0000, 0, 0, 2'd0, 8'h00, 1);
        cyc(4'b0000, 0, 1, 2'd0, 8'h82, 0);
        cyc(4'b0000, 0, 1, 2'd1, 8'hFC, 0);
        cyc(4'b0010, 0, 0, 2'd1, 8'h00, 0);
        cyc(4'b0000, 0, 0, 2'd1, 8'h00, 0);
        check("r24_vec", int_vec, 8'h00);
        idle(2, 2'd3);

        // Set beats W1C clear while in service; no request until ret.
        cyc(4'b0000, 0, 0, 2'd0, 8'h00, 1);
        cyc(4'b0000, 0, 1, 2'd0, 8'h81, 0);
        cyc(4'b0000, 0, 1, 2'd1, 8'h10, 0);
        cyc(4'b0001, 0, 0, 2'd2, 8'h00, 0);
        cyc(4'b0000, 0, 0, 2'd2, 8'h00, 0);
        idle(1, 2'd2);
        cyc(4'b0001, 0, 1, 2'd2, 8'h01, 0);
        check("r25_pend", bus_r_data, 8'h01);
        idle(3, 2'd2);
        check("r25_noreq", {7'b0, int_req}, 8'h00);
        cyc(4'b0000, 1, 0, 2'd2, 8'h00, 0);
        cyc(4'b0000, 0, 0, 2'd2, 8'h00, 0);
        check("r25_redisp", {7'b0, int_req}, 8'h01);
        idle(2, 2'd3);

        // Reset during service discards everything.
        cyc(4'b0000, 0, 1, 2'd0, 8'h8F, 0);
        cyc(4'b0110, 0, 0, 2'd2, 8'h00, 0);
        idle(2, 2'd2);
        cyc(4'b0000, 0, 0, 2'd3, 8'h00, 1);
        check("r26_req", {7'b0, int_req}, 8'h00);
        check("r26_en", int_en, 8'h00);
        check("r26_vec", int_vec, 8'h00);
        check("r26_stat", bus_r_data, 8'h00);
        idle(4, 2'd2);
        check("r26_pend", bus_r_data, 8'h00);

        // Random traffic against the model.
        irq_drv = 4'b0000;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) irq_drv[b] = ~irq_drv[b];
            rw = ($urandom_range(0, 3) == 0);
            ra = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            if (rw && ra == 2'd0) rd[7] = ($urandom_range(0, 3) != 0);
            cyc(irq_drv, ($urandom_range(0, 5) == 0), rw, ra, rd,
                ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL expose ports, in this order:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- irq_src  in  4  interrupt sources, rising-edge sensitive
- cpu_ret  in  1  one-cycle pulse when the CPU executes ret
- bus_w_en  in  1  register write strobe
- bus_addr  in  2  register select
- bus_w_data  in  8  register write data
- bus_r_data  out  8  register read data, combinational
- int_req  out  1  interrupt request to CPU, registered
- int_en  out  8  {7'b0, gie} to CPU, registered
- int_vec  out  8  dispatch vector to CPU, registered

Function
REQ-003 SHALL provide the following register map:
- 0 = CTRL {gie, 3'b0, mask[3:0]}, read/write.
- 1 = VBASE [7:0], read/write.
- 2 = PEND {4'b0, pending[3:0]}; reads return pending; writing 1 to a bit clears it.
- 3 = STAT {state[1:0], 2'b0, in_svc, cur_src[1:0], int_req}, read-only; writes are ignored.
REQ-004 SHALL detect edges using prev[i], which is sampled every clock; pending[i] is set at the edge where irq_src[i]=1 and prev[i]=0.
REQ-005 SHALL make set win over clear when a W1C clear and a new edge hit the same pending bit in the same cycle.
REQ-006 SHALL record edges from masked sources in pending; masking blocks dispatch only.
REQ-007 SHALL implement the states IDLE=0, DISPATCH=1 and IN_SERVICE=2; encoding 3 is illegal and returns to IDLE at the next clock.
REQ-008 IDLE -> DISPATCH SHALL occur when gie=1 and (pending & mask) != 0.
- On that edge, latch cur_src = the lowest set index of (pending & mask).
- Clear pending[cur_src] on the same edge.
- Register int_vec = VBASE + {cur_src, 2'b00}, using 8-bit modulo-256 wrap.
REQ-009 SHALL hold int_req=1 for exactly one cycle, and only while in DISPATCH.
REQ-010 DISPATCH SHALL go to IN_SERVICE unconditionally at the next clock, setting in_svc=1.
REQ-011 IN_SERVICE SHALL go to IDLE at the edge where cpu_ret=1, clearing in_svc.
- cpu_ret in IDLE or DISPATCH is ignored.
REQ-012 SHALL not preempt: new edges arriving during DISPATCH or IN_SERVICE only set pending.
REQ-013 SHALL not abort service when gie is cleared in DISPATCH or IN_SERVICE; gie gates only the IDLE -> DISPATCH transition.
REQ-014 SHALL give a bus write to CTRL or VBASE effect from the next clock.
- A write on the same edge as a dispatch decision does not affect that decision or its vector.
REQ-015 SHALL meet this latency: source rising in the cycle before edge k -> pending set at k -> int_req high during the cycle after k+1 -> CPU vectors at edge k+2.
REQ-016 SHALL retain int_vec after DISPATCH until the next dispatch.
REQ-017 SHALL allow the earliest re-dispatch at the clock after the edge that returns the block to IDLE.

Reset
REQ-018 On reset=1 at a clock edge, SHALL set:
- state=IDLE, int_req=0, int_en=0, int_vec=0.
- gie=0, mask=0, VBASE=0, pending=0, prev=0, cur_src=0, in_svc=0.
REQ-019 SHALL abandon service on reset during DISPATCH or IN_SERVICE, returning to IDLE with no pending interrupt retained.
REQ-020 SHALL register a pending edge for a source already high when reset deasserts, because prev resets to 0.

Verification
REQ-021 Setup CTRL=0x81, VBASE=0x40; pulse irq_src[0] -> int_req=1 for one cycle two clocks later, int_vec=0x40, STAT.in_svc=1; then cpu_ret -> IDLE.
REQ-022 With CTRL=0x8F, raise irq_src[3] and irq_src[1] in the same cycle:
- First dispatch is src 1, int_vec=VBASE+4.
- After cpu_ret, src 3 dispatches, int_vec=VBASE+12.
REQ-023 With CTRL=0x0F, edge on irq_src[2] -> PEND=0x04 and int_req stays 0; write CTRL=0x8F -> dispatch of src 2; PEND=0x00.
REQ-024 With VBASE=0xFC and src 1 dispatched -> int_vec=0x00 (wrap).
REQ-025 In IN_SERVICE, edge on irq_src[0] coincident with a PEND write of 0x01 -> PEND=0x01 (set wins), and no int_req until cpu_ret.
REQ-026 Assert reset during IN_SERVICE with PEND=0x06 -> all outputs 0, STAT=0x00, and no dispatch after reset until new edges arrive.
